// File: rtl/cursor_ctrl.sv
// Paint-pipeline front end: synchronises and debounces the buttons, auto-repeats directions,
// owns cursor position/colour and issues pixel writes plus save/undo/redo pulses to the history buffer.
module cursor_ctrl #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 2000,
  parameter int REPEAT_PERIOD = 500,
  parameter int X_MAX         = 159,
  parameter int Y_MAX         = 119,
  parameter int COLOR_RST     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_color,
  input  logic       btn_pen,
  input  logic       btn_undo,
  input  logic       btn_redo,
  input  logic       restore_valid,
  input  logic [7:0] x_rst,
  input  logic [7:0] y_rst,
  input  logic [2:0] color_rst,
  output logic [7:0] cursor_x,
  output logic [7:0] cursor_y,
  output logic [2:0] color,
  output logic       pixel_we,
  output logic       save,
  output logic       undo,
  output logic       redo
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int RPW = $clog2(REPEAT_DELAY + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [RPW-1:0] RP_LAST   = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_RELOAD = RPW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [7:0]     XM        = 8'(X_MAX);
  localparam logic [7:0]     YM        = 8'(Y_MAX);
  localparam logic [2:0]     C_RST     = 3'(COLOR_RST);

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
  localparam int B_COLOR = 4, B_PEN = 5, B_UNDO = 6, B_REDO = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [7:0]     raw, sync1, sync2, lvl, lvl_nxt, rise;
  logic [DBW-1:0] db_cnt [8];
  logic [DBW-1:0] db_cnt_nxt [8];
  logic [RPW-1:0] rpt_cnt;
  logic [3:0]     dir_lvl;
  logic           one_dir, rpt_fire;
  logic [7:0]     flag, flag_set, flag_clr;
  logic [1:0]     state, state_nxt, wait_cnt, wait_cnt_nxt;
  logic [7:0]     x_nxt, y_nxt, mv_x, mv_y;
  logic [2:0]     c_nxt;
  logic           we_nxt, save_nxt, undo_nxt, redo_nxt, moved;

  assign raw = {btn_redo, btn_undo, btn_pen, btn_color, btn_right, btn_left, btn_down, btn_up};

  // Debounce: a level flips on the DB_CYCLES-th consecutive synced sample that disagrees with it
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl_nxt[i]    = lvl[i];
      db_cnt_nxt[i] = '0;
      if (sync2[i] != lvl[i]) begin
        if (db_cnt[i] == DB_LAST) lvl_nxt[i] = ~lvl[i];
        else                      db_cnt_nxt[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  assign rise = lvl_nxt & ~lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl   <= lvl_nxt;
      for (int i = 0; i < 8; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end

  // Auto-repeat: first re-trigger REPEAT_DELAY after the press, then every REPEAT_PERIOD
  assign dir_lvl  = lvl[3:0];
  assign one_dir  = $onehot(dir_lvl);
  assign rpt_fire = one_dir && (rpt_cnt == RP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rpt_cnt <= '0;
    else if (dir_lvl == 4'b0) rpt_cnt <= '0;
    else if (one_dir)        rpt_cnt <= rpt_fire ? RP_RELOAD : rpt_cnt + 1'b1;
  end

  assign flag_set = rise | {4'b0, (rpt_fire ? dir_lvl : 4'b0)};

  // Opposing directions cancel; movement saturates at the legal edges
  always_comb begin
    mv_x = cursor_x;
    mv_y = cursor_y;
    if (flag[B_LEFT] && !flag[B_RIGHT] && cursor_x != 8'd0)    mv_x = cursor_x - 8'd1;
    else if (flag[B_RIGHT] && !flag[B_LEFT] && cursor_x < XM) mv_x = cursor_x + 8'd1;
    if (flag[B_UP] && !flag[B_DOWN] && cursor_y != 8'd0)       mv_y = cursor_y - 8'd1;
    else if (flag[B_DOWN] && !flag[B_UP] && cursor_y < YM)     mv_y = cursor_y + 8'd1;
    moved = (mv_x != cursor_x) || (mv_y != cursor_y);
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    flag_clr     = '0;
    x_nxt        = cursor_x;
    y_nxt        = cursor_y;
    c_nxt        = color;
    we_nxt       = 1'b0;
    save_nxt     = 1'b0;
    undo_nxt     = 1'b0;
    redo_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (flag[B_UNDO]) begin
          undo_nxt         = 1'b1;
          flag_clr[B_UNDO] = 1'b1;
          state_nxt        = S_WAIT;
        end else if (flag[B_REDO]) begin
          redo_nxt         = 1'b1;
          flag_clr[B_REDO] = 1'b1;
          state_nxt        = S_WAIT;
        end else if (flag[B_COLOR]) begin
          c_nxt             = color + 3'd1;
          flag_clr[B_COLOR] = 1'b1;
        end else if (|flag[3:0]) begin
          x_nxt            = mv_x;
          y_nxt            = mv_y;
          flag_clr[3:0]    = 4'hF;
          flag_clr[B_PEN]  = 1'b1;
          if (lvl[B_PEN] && moved) state_nxt = S_WRITE;
        end else if (flag[B_PEN]) begin
          flag_clr[B_PEN] = 1'b1;
          state_nxt       = S_WRITE;
        end
      end
      S_WRITE: begin
        we_nxt    = 1'b1;
        save_nxt  = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP: state_nxt = S_IDLE;
      S_WAIT: begin
        if (restore_valid) begin
          x_nxt     = x_rst;
          y_nxt     = y_rst;
          c_nxt     = color_rst;
          state_nxt = S_GAP;
        end else if (wait_cnt == 2'd3) begin
          state_nxt = S_GAP;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered state, cursor and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      flag     <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      color    <= C_RST;
      pixel_we <= 1'b0;
      save     <= 1'b0;
      undo     <= 1'b0;
      redo     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      flag     <= (flag & ~flag_clr) | flag_set;
      cursor_x <= x_nxt;
      cursor_y <= y_nxt;
      color    <= c_nxt;
      pixel_we <= we_nxt;
      save     <= save_nxt;
      undo     <= undo_nxt;
      redo     <= redo_nxt;
    end
  end

endmodule
